pipe_hazard_ctrl: RTL and testbench

Owns the F/D, D/X, X/M and M/W instruction latches of the 5-stage pipeline. Drives the fd_insn/dx_insn/xm_insn words consumed by the bypass unit. Generates load-use stalls, multdiv hold, and taken-branch flushes. Also gates PC write-enable.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/md_hold_fsm.sv | 76 +++++++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: instruction field
// positions, opcode / ALU-op encodings, the bubble word and the multdiv
// hold state type.
package pipe_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // True for an R-type mul or div, the only instructions that need the hold.
    function automatic logic is_multdiv(input logic [31:0] insn);
        return (insn[OPC_HI:OPC_LO] == OP_RTYPE) &&
               ((insn[ALU_HI:ALU_LO] == ALU_MUL) || (insn[ALU_HI:ALU_LO] == ALU_DIV));
    endfunction

endpackage

// File: rtl/md_hold_fsm.sv
// Multdiv hold sequencer: starts the multdiv unit when D/X holds a mul/div,
// keeps the front of the pipe frozen for MD_LATENCY cycles, then releases
// it for one advance cycle while flagging the result as valid.
//
// state | meaning
// IDLE  | no multdiv in flight; pulses start if D/X holds a mul/div
// BUSY  | multdiv running, down-counter tracks remaining hold cycles
// DONE  | result valid, D/X advances this edge (no retrigger)
module md_hold_fsm
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_md_insn,
    output logic o_md_start,
    output logic o_md_busy,
    output logic o_md_done,
    output logic o_hold
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    md_state_e         r_state;
    md_state_e         w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;

    // State and down-counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: BUSY exits once the counter reaches its terminal count of 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_md_insn) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CW'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode from the current state and the D/X contents.
    always_comb begin
        o_md_start = (r_state == IDLE) && i_md_insn;
        o_md_busy  = (r_state == BUSY);
        o_md_done  = (r_state == DONE);
        o_hold     = o_md_start || o_md_busy;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: owns the F/D, D/X, X/M and M/W instruction
// latches, inserts load-use bubbles, holds the front of the pipe during
// multdiv, flushes on taken branches and gates the PC write enable.
// Optional build macro STALL_PERF_EN adds stall_cycles / flush_count.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int          MD_LATENCY = 32,
    parameter logic [31:0] NOP        = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] imem_insn,
    input  logic        flush,
    output logic        pc_we,
    output logic [31:0] fd_insn,
    output logic [31:0] dx_insn,
    output logic [31:0] xm_insn,
    output logic [31:0] mw_insn,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    logic [31:0] r_fd;
    logic [31:0] r_dx;
    logic [31:0] r_xm;
    logic [31:0] r_mw;

    logic [4:0]  w_fd_op;
    logic [4:0]  w_dx_op;
    logic [4:0]  w_dx_rd;
    logic [4:0]  w_src_a;
    logic [4:0]  w_src_b;
    logic        w_load_use;
    logic        w_md_insn;
    logic        w_hold;

    assign w_fd_op   = r_fd[OPC_HI:OPC_LO];
    assign w_dx_op   = r_dx[OPC_HI:OPC_LO];
    assign w_dx_rd   = r_dx[RD_HI:RD_LO];
    assign w_md_insn = is_multdiv(r_dx);

    // Source registers read by the instruction in F/D; unused slots read r0,
    // which can never match a load destination because r0 is excluded.
    always_comb begin
        w_src_a = 5'd0;
        w_src_b = 5'd0;
        case (w_fd_op)
            OP_RTYPE: begin
                w_src_a = r_fd[RS_HI:RS_LO];
                w_src_b = r_fd[RT_HI:RT_LO];
            end
            OP_ADDI, OP_LW: begin
                w_src_a = r_fd[RS_HI:RS_LO];
            end
            OP_SW, OP_BNE, OP_BLT: begin
                w_src_a = r_fd[RD_HI:RD_LO];
                w_src_b = r_fd[RS_HI:RS_LO];
            end
            OP_JR: begin
                w_src_a = r_fd[RD_HI:RD_LO];
            end
            default: begin
                w_src_a = 5'd0;
                w_src_b = 5'd0;
            end
        endcase
    end

    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                        ((w_dx_rd == w_src_a) || (w_dx_rd == w_src_b));

    md_hold_fsm #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_hold_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_md_insn  (w_md_insn),
        .o_md_start (md_start),
        .o_md_busy  (md_busy),
        .o_md_done  (md_done),
        .o_hold     (w_hold)
    );

    // A flush overrides a coincident load-use, so the PC keeps moving then.
    assign pc_we = !w_hold && (flush || !w_load_use);

    // Instruction latches: multdiv hold > flush > load-use > normal advance;
    // M/W always drains from X/M.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fd <= NOP;
            r_dx <= NOP;
            r_xm <= NOP;
            r_mw <= NOP;
        end else begin
            r_mw <= r_xm;
            if (w_hold) begin
                r_xm <= NOP;
            end else if (flush) begin
                r_fd <= NOP;
                r_dx <= NOP;
                r_xm <= r_dx;
            end else if (w_load_use) begin
                r_dx <= NOP;
                r_xm <= r_dx;
            end else begin
                r_fd <= imem_insn;
                r_dx <= r_fd;
                r_xm <= r_dx;
            end
        end
    end

    assign fd_insn = r_fd;
    assign dx_insn = r_dx;
    assign xm_insn = r_xm;
    assign mw_insn = r_mw;

`ifdef STALL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Performance counters; a flush swallowed by the multdiv hold is not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!pc_we) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush && !w_hold) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random instruction streams, predicted cycle by cycle by a behavioural
// pipeline model and checked by a separate scoreboard monitor.
module tb_pipe_hazard_ctrl;

    localparam int L = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] imem_insn = 32'h0;
    logic        flush = 1'b0;
    logic        pc_we;
    logic [31:0] fd_insn, dx_insn, xm_insn, mw_insn;
    logic        md_start, md_busy, md_done;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(
        .MD_LATENCY (L),
        .NOP        (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .imem_insn (imem_insn),
        .flush     (flush),
        .pc_we     (pc_we),
        .fd_insn   (fd_insn),
        .dx_insn   (dx_insn),
        .xm_insn   (xm_insn),
        .mw_insn   (mw_insn),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_done   (md_done)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pc_we;
        logic        st;
        logic        bz;
        logic        dn;
        logic [31:0] fd;
        logic [31:0] dx;
        logic [31:0] xm;
        logic [31:0] mw;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done_stim = 1'b0;

    // Reference pipeline: four latches plus how long the current D/X
    // instruction has sat there.
    logic [31:0] m_fd, m_dx, m_xm, m_mw;
    int          m_age;
    logic [31:0] m_stalls, m_flushes;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] alu);
        return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return (i[31:27] == 5'd0) && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
    endfunction

    function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
        case (i[31:27])
            5'd0:       return (r == i[21:17]) || (r == i[16:12]);
            5'd5, 5'd8: return (r == i[21:17]);
            5'd7, 5'd2, 5'd6: return (r == i[26:22]) || (r == i[21:17]);
            5'd4:       return (r == i[26:22]);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit load_use(input logic [31:0] fd, input logic [31:0] dx);
        return (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && reads(fd, dx[26:22]);
    endfunction

    task automatic model_reset();
        m_fd = 32'h0; m_dx = 32'h0; m_xm = 32'h0; m_mw = 32'h0;
        m_age = 0; m_stalls = 32'h0; m_flushes = 32'h0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, predict this cycle's outputs, advance the model.
    task automatic drive(input logic [31:0] insn, input bit fl);
        exp_t        e;
        bit          md, st, bz, dn, hold, lu, pc;
        int          a;
        logic [31:0] n_fd, n_dx, n_xm;
        @(posedge clock);
        #1;
        imem_insn = insn;
        flush     = fl;
        md   = is_md(m_dx);
        a    = md ? m_age + 1 : 0;
        st   = md && (a == 1);
        bz   = md && (a >= 2) && (a <= L);
        dn   = md && (a == L + 1);
        hold = st || bz;
        lu   = load_use(m_fd, m_dx);
        pc   = !hold && (fl || !lu);
        e.pc_we = pc; e.st = st; e.bz = bz; e.dn = dn;
        e.fd = m_fd; e.dx = m_dx; e.xm = m_xm; e.mw = m_mw;
        e.stalls = m_stalls; e.flushes = m_flushes;
        q.push_back(e);
        n_fd = m_fd; n_dx = m_dx;
        if (hold) begin
            n_xm = 32'h0;
        end else if (fl) begin
            n_fd = 32'h0; n_dx = 32'h0; n_xm = m_dx;
            m_flushes = m_flushes + 32'd1;
        end else if (lu) begin
            n_dx = 32'h0; n_xm = m_dx;
        end else begin
            n_fd = insn; n_dx = m_fd; n_xm = m_dx;
        end
        m_age = hold ? a : 0;
        if (!pc) m_stalls = m_stalls + 32'd1;
        m_mw = m_xm; m_xm = n_xm; m_dx = n_dx; m_fd = n_fd;
    endtask

    function automatic logic [31:0] rnd_insn();
        logic [4:0]  ops [10];
        logic [31:0] w;
        ops = '{5'd0, 5'd0, 5'd5, 5'd8, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd3};
        w = $urandom;
        w[31:27] = ops[$urandom_range(0, 9)];
        w[26:22] = 5'($urandom_range(0, 3));
        w[21:17] = 5'($urandom_range(0, 3));
        w[16:12] = 5'($urandom_range(0, 3));
        if (w[31:27] == 5'd0) w[6:2] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // Scoreboard monitor: pops one prediction per presented cycle.
    initial begin : monitor
        exp_t e;
        int   idle;
        idle = 0;
        forever begin
            @(posedge clock);
            #3;
            if (q.size() > 0) begin
                idle = 0;
                e = q.pop_front();
                chk("pc_we",    32'(pc_we),    32'(e.pc_we));
                chk("md_start", 32'(md_start), 32'(e.st));
                chk("md_busy",  32'(md_busy),  32'(e.bz));
                chk("md_done",  32'(md_done),  32'(e.dn));
                chk("fd_insn",  fd_insn, e.fd);
                chk("dx_insn",  dx_insn, e.dx);
                chk("xm_insn",  xm_insn, e.xm);
                chk("mw_insn",  mw_insn, e.mw);
`ifdef STALL_PERF_EN
                chk("stall_cycles", stall_cycles, e.stalls);
                chk("flush_count",  flush_count,  e.flushes);
`endif
            end else if (!done_stim) begin
                idle++;
                if (idle > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor_timeout: got no prediction for %0d cycles expected one per cycle", idle);
                    idle = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of stimulus expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] nop_w, add_w;
        nop_w = 32'h0;
        add_w = mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Load-use: lw r3,0(r1); add r4,r3,r2
        drive(mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0);
        drive(mk(5'd0, 5'd4, 5'd3, 5'd2, 5'd0), 1'b0);
        repeat (4) drive(nop_w, 1'b0);

        // r0 never hazards: lw r0; add r4,r0,r2
        drive(mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), 1'b0);
        drive(mk(5'd0, 5'd4, 5'd0, 5'd2, 5'd0), 1'b0);
        repeat (4) drive(nop_w, 1'b0);

        // Multdiv hold: mul r5,r6,r7 followed by independent adds
        drive(mk(5'd0, 5'd5, 5'd6, 5'd7, 5'd6), 1'b0);
        repeat (9) drive(add_w, 1'b0);
        repeat (3) drive(nop_w, 1'b0);

        // Taken branch: flush while bne sits in D/X
        drive(mk(5'd2, 5'd1, 5'd2, 5'd0, 5'd0), 1'b0);
        drive(mk(5'd5, 5'd1, 5'd1, 5'd0, 5'd0), 1'b0);
        drive(mk(5'd5, 5'd2, 5'd2, 5'd0, 5'd0), 1'b1);
        repeat (3) drive(nop_w, 1'b0);

        // Flush coinciding with a load-use condition
        drive(mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0);
        drive(mk(5'd0, 5'd4, 5'd3, 5'd2, 5'd0), 1'b0);
        drive(nop_w, 1'b1);
        repeat (3) drive(nop_w, 1'b0);

        // Reset in the second BUSY cycle of a div
        drive(mk(5'd0, 5'd5, 5'd6, 5'd7, 5'd7), 1'b0);
        repeat (4) drive(nop_w, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_fd",      fd_insn, 32'h0);
        chk("rst_dx",      dx_insn, 32'h0);
        chk("rst_xm",      xm_insn, 32'h0);
        chk("rst_mw",      mw_insn, 32'h0);
        chk("rst_md_busy", 32'(md_busy), 32'h0);
        chk("rst_md_done", 32'(md_done), 32'h0);
        chk("rst_pc_we",   32'(pc_we),   32'h1);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (8) drive(nop_w, 1'b0);

        // Random instruction streams with occasional flushes
        repeat (500) drive(rnd_insn(), ($urandom_range(0, 9) == 0));
        drive(nop_w, 1'b0);

        repeat (3) @(posedge clock);
        #5;
        done_stim = 1'b1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
